ram_ctrl: RTL and testbench
===========================

// Module: ram_ctrl
// PURPOSE
//   Initiator-side controller for the 8x8 single-port RAM block. Accepts read/write
//   requests on a valid/ready interface, drives the RAM adr/data_in/write_signal
//   pins, returns read data as a one-cycle response pulse, and runs a whole-array
//   clear sequence on command. Sits between datapath logic and the RAM instance.
// PARAMETERS
//   DATA_W        8   RAM word width
//   ADDR_W        3   RAM address width; DEPTH = 2**ADDR_W
//   READ_LATENCY  1   cycles from ram_adr stable to ram_data_out valid (0..3)
//   CLEAR_VALUE   0   word written to every location during clear
// PORTS
//   clock             in   1       single clock, all logic on rising edge
//   reset             in   1       synchronous, active-low
//   req_valid         in   1       request present
//   req_ready         out  1       controller can accept request this cycle
//   req_write         in   1       1 = write, 0 = read
//   req_adr           in   ADDR_W  request address
//   req_wdata         in   DATA_W  write data
//   rsp_valid         out  1       one-cycle pulse: rsp_data holds read result
//   rsp_data          out  DATA_W  last read data, held until next read completes
//   clr_start         in   1       start clear of entire array (sampled in IDLE)
//   clr_done          out  1       one-cycle pulse after final clear write
//   busy              out  1       state != IDLE
//   ram_adr           out  ADDR_W  to RAM adr
//   ram_data_in       out  DATA_W  to RAM data_in
//   ram_write_signal  out  1       to RAM write_signal
//   ram_data_out      in   DATA_W  from RAM data_out
// BEHAVIOUR
//   - Reset (reset==0 at edge): state=IDLE; all outputs 0 incl. req_ready,
//     ram_write_signal, rsp_data. Reset mid-operation aborts immediately; no
//     further RAM writes; pending read response discarded.
//   - All RAM-side outputs and rsp_*/clr_done/busy are registered.
//     req_ready = (state==IDLE) && !clr_start && reset (combinational).
//   - States: IDLE, WRITE, READ, RESP, CLEAR.
//   - IDLE: clr_start=1 -> CLEAR (priority; same-cycle req NOT accepted),
//     ram_adr<=0. Else req_valid&&req_ready: latch adr/wdata; write -> WRITE,
//     read -> READ; ram_adr<=req_adr.
//   - WRITE: exactly one cycle, ram_write_signal=1, ram_adr/ram_data_in = latched
//     values; -> IDLE. Write throughput: one per 2 cycles.
//   - READ: ram_write_signal=0, ram_adr held; lasts READ_LATENCY+1 cycles (counter);
//     ram_data_out sampled into rsp_data at edge ending last READ cycle -> RESP.
//   - RESP: rsp_valid=1 one cycle; -> IDLE. Accept edge E0 -> rsp_valid high in
//     cycle E0+2+READ_LATENCY. No response backpressure.
//   - CLEAR: ram_write_signal=1 for DEPTH consecutive cycles, ram_adr 0..DEPTH-1
//     ascending, ram_data_in=CLEAR_VALUE; address counter width ADDR_W, terminates
//     at DEPTH-1 (no wrap); clr_done=1 in the cycle after last write, state IDLE.
//   - clr_start while busy: ignored. req_* while busy: not accepted (ready=0).
//   - ram_write_signal never high outside WRITE/CLEAR; ram_data_in holds last value.
// TESTING
//   1. reset=0 for 2 cycles -> all outputs 0, req_ready=0; reset=1 -> req_ready=1.
//   2. write adr=1 data=5 -> next cycle ram_write_signal=1, ram_adr=1,
//      ram_data_in=5, req_ready=0; following cycle ram_write_signal=0, ready=1.
//   3. read adr=1 after (2), READ_LATENCY=1 -> rsp_valid pulse at E0+3, rsp_data=5;
//      read adr=0 (unwritten, after clear) -> rsp_data=CLEAR_VALUE.
//   4. clr_start pulse -> 8 consecutive writes adr 0..7 data 0, busy=1 throughout,
//      clr_done pulse next cycle; read adr=1 returns 0.
//   5. clr_start and req_valid (write adr 2 data 9) same cycle -> clear runs, write
//      accepted only after clr_done; read adr 2 then returns 9.
//   6. write 0xAA to adr 5; clr_start; reset=0 when ram_adr=3 -> ram_write_signal=0
//      next cycle, no clr_done; read adr 5 returns 0xAA.

Source files
------------

// File: rtl/ram_ctrl.sv
// ram_ctrl: initiator-side controller for the 8x8 single-port RAM block.
// It accepts read/write requests on a valid/ready handshake and drives the RAM
// address, data and write pins from registers. Read data comes back as a
// one-cycle response pulse. On command, it writes CLEAR_VALUE to every location.

module ram_ctrl #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned CLEAR_VALUE  = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              clr_start,
  output logic              clr_done,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_signal,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RESP,
    S_CLEAR
  } state_t;

  // The read counter runs from 0 to READ_LATENCY. Its range is 0..3, so 2 bits are enough.
  localparam logic [1:0]        RD_LAST  = 2'(READ_LATENCY);
  localparam logic [ADDR_W-1:0] LAST_ADR = '1;
  localparam logic [DATA_W-1:0] CLR_WORD = DATA_W'(CLEAR_VALUE);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ram_adr;
  logic [ADDR_W-1:0] w_ram_adr_nxt;
  logic [DATA_W-1:0] r_ram_din;
  logic [DATA_W-1:0] w_ram_din_nxt;
  logic              r_ram_we;
  logic              w_ram_we_nxt;
  logic              r_rsp_valid;
  logic              w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_data;
  logic [DATA_W-1:0] w_rsp_data_nxt;
  logic              r_clr_done;
  logic              w_clr_done_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic [1:0]        r_rd_cnt;
  logic [1:0]        w_rd_cnt_nxt;
  logic              w_req_ready;

  // A clear command on the same cycle takes priority, so ready drops immediately.
  assign w_req_ready = (r_state == S_IDLE) && !clr_start && reset;

  // State and registered outputs. Reset aborts any operation on the next edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ram_adr   <= '0;
      r_ram_din   <= '0;
      r_ram_we    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_clr_done  <= 1'b0;
      r_busy      <= 1'b0;
      r_rd_cnt    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ram_adr   <= w_ram_adr_nxt;
      r_ram_din   <= w_ram_din_nxt;
      r_ram_we    <= w_ram_we_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_clr_done  <= w_clr_done_nxt;
      r_busy      <= w_busy_nxt;
      r_rd_cnt    <= w_rd_cnt_nxt;
    end
  end

  // Next state and next values for the registered outputs.
  // The write strobe is computed one cycle early so that its register is high
  // exactly during the WRITE and CLEAR cycles.
  always_comb begin
    w_state_nxt     = r_state;
    w_ram_adr_nxt   = r_ram_adr;
    w_ram_din_nxt   = r_ram_din;
    w_ram_we_nxt    = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_clr_done_nxt  = 1'b0;
    w_rd_cnt_nxt    = r_rd_cnt;

    unique case (r_state)
      S_IDLE: begin
        if (clr_start) begin
          w_state_nxt   = S_CLEAR;
          w_ram_adr_nxt = '0;
          w_ram_din_nxt = CLR_WORD;
          w_ram_we_nxt  = 1'b1;
        end else if (req_valid && w_req_ready) begin
          w_ram_adr_nxt = req_adr;
          w_rd_cnt_nxt  = '0;
          if (req_write) begin
            w_state_nxt   = S_WRITE;
            w_ram_din_nxt = req_wdata;
            w_ram_we_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_READ;
          end
        end
      end

      S_WRITE: begin
        w_state_nxt = S_IDLE;
      end

      S_READ: begin
        if (r_rd_cnt == RD_LAST) begin
          w_rsp_data_nxt  = ram_data_out;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
        end else begin
          w_rd_cnt_nxt = r_rd_cnt + 2'd1;
        end
      end

      S_RESP: begin
        w_state_nxt = S_IDLE;
      end

      S_CLEAR: begin
        if (r_ram_adr == LAST_ADR) begin
          w_state_nxt    = S_IDLE;
          w_clr_done_nxt = 1'b1;
        end else begin
          w_ram_adr_nxt = r_ram_adr + 1'b1;
          w_ram_we_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign req_ready        = w_req_ready;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_data         = r_rsp_data;
  assign clr_done         = r_clr_done;
  assign busy             = r_busy;
  assign ram_adr          = r_ram_adr;
  assign ram_data_in      = r_ram_din;
  assign ram_write_signal = r_ram_we;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed bench for ram_ctrl, built around a behavioural
// 8x8 RAM with one cycle of read latency. Expected read data comes from a
// shadow copy of the memory. It is queued when a read is issued and
// compared when the response pulse appears.

module tb_ram_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned RL = 1;
  localparam int unsigned CV = 0;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          clr_start;
  logic          clr_done;
  logic          busy;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_data_in;
  logic          ram_write_signal;
  logic [DW-1:0] ram_data_out;

  logic [DW-1:0] mem   [8];
  logic [DW-1:0] model [8];
  logic [DW-1:0] sb    [$];

  int n_tests = 0;
  int n_fail  = 0;

  ram_ctrl #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .READ_LATENCY(RL),
    .CLEAR_VALUE (CV)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_adr         (req_adr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .clr_start       (clr_start),
    .clr_done        (clr_done),
    .busy            (busy),
    .ram_adr         (ram_adr),
    .ram_data_in     (ram_data_in),
    .ram_write_signal(ram_write_signal),
    .ram_data_out    (ram_data_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural RAM: synchronous write, registered read (latency 1)
  always @(posedge clock) begin
    if (ram_write_signal) mem[ram_adr] <= ram_data_in;
    ram_data_out <= mem[ram_adr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every rsp_valid pulse pops one scoreboard entry
  always @(negedge clock) begin
    if (rsp_valid === 1'b1) begin
      int n;
      n = sb.size();
      check("rsp_expected", 32'(n != 0), 32'd1);
      if (n != 0) check("rsp_data", 32'(rsp_data), 32'(sb.pop_front()));
    end
  end

  // Offers a request and waits (bounded) for it to be accepted.
  // Returns with the accept edge 1 ns in the past.
  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int unsigned waited);
    waited = 0;
    @(negedge clock);
    req_valid = 1'b1;
    req_write = wr;
    req_adr   = a;
    req_wdata = d;
    #1;
    while (!req_ready && waited < 50) begin
      @(negedge clock);
      #1;
      waited++;
    end
    check("accept_in_time", 32'(waited < 50), 32'd1);
    if (wr) model[a] = d;
    else    sb.push_back(model[a]);
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int unsigned w;
    int unsigned k;
    logic [DW-1:0] exp;
    exp = model[a];
    send(1'b0, a, '0, w);
    k = 0;
    while (k < RL + 6) begin
      @(negedge clock);
      k++;
      if (rsp_valid === 1'b1) break;
    end
    check("rsp_latency", k, RL + 2);
    @(negedge clock);
    check("rsp_pulse_end", 32'(rsp_valid), 32'd0);
    check("rsp_data_held", 32'(rsp_data), 32'(exp));
  endtask

  task automatic wait_idle();
    int unsigned w;
    w = 0;
    while (busy !== 1'b0 && w < 50) begin
      @(negedge clock);
      w++;
    end
    check("idle_in_time", 32'(w < 50), 32'd1);
  endtask

  // Checks the full clear burst and the clr_done cycle that follows it.
  // Called right after the edge that accepted clr_start.
  task automatic clear_seq();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("clr_we",    32'(ram_write_signal), 32'd1);
      check("clr_adr",   32'(ram_adr),          32'(i));
      check("clr_din",   32'(ram_data_in),      32'(CV));
      check("clr_busy",  32'(busy),             32'd1);
      check("clr_ready", 32'(req_ready),        32'd0);
      check("clr_nodone", 32'(clr_done),        32'd0);
    end
    @(negedge clock);
    check("clr_done",    32'(clr_done),         32'd1);
    check("clr_end_we",  32'(ram_write_signal), 32'd0);
    check("clr_end_busy", 32'(busy),            32'd0);
    for (int i = 0; i < 8; i++) model[i] = DW'(CV);
  endtask

  initial begin
    int unsigned w;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_adr   = '0;
    req_wdata = '0;
    clr_start = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 'x;

    // 1: reset state
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("rst_ready", 32'(req_ready),        32'd0);
    check("rst_we",    32'(ram_write_signal), 32'd0);
    check("rst_adr",   32'(ram_adr),          32'd0);
    check("rst_din",   32'(ram_data_in),      32'd0);
    check("rst_rspv",  32'(rsp_valid),        32'd0);
    check("rst_rspd",  32'(rsp_data),         32'd0);
    check("rst_done",  32'(clr_done),         32'd0);
    check("rst_busy",  32'(busy),             32'd0);
    reset = 1'b1;
    #1;
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // 2: a single write, followed by a back-to-back write (2-cycle throughput)
    send(1'b1, 3'd1, 8'd5, w);
    @(negedge clock);
    check("wr_we",    32'(ram_write_signal), 32'd1);
    check("wr_adr",   32'(ram_adr),          32'd1);
    check("wr_din",   32'(ram_data_in),      32'd5);
    check("wr_ready", 32'(req_ready),        32'd0);
    check("wr_busy",  32'(busy),             32'd1);
    @(negedge clock);
    check("wr_end_we",    32'(ram_write_signal), 32'd0);
    check("wr_end_ready", 32'(req_ready),        32'd1);
    check("wr_end_din",   32'(ram_data_in),      32'd5);
    send(1'b1, 3'd6, 8'h3c, w);
    send(1'b1, 3'd7, 8'hc3, w);
    check("wr_throughput_wait", w, 32'd1);

    // 3: reads, including response latency and hold of rsp_data
    do_read(3'd1);
    do_read(3'd6);
    do_read(3'd7);

    // 4: full clear, then reads of cleared locations
    wait_idle();
    @(negedge clock);
    clr_start = 1'b1;
    @(posedge clock);
    #1 clr_start = 1'b0;
    clear_seq();
    @(negedge clock);
    check("done_pulse_end", 32'(clr_done), 32'd0);
    do_read(3'd1);
    do_read(3'd0);

    // 5: clr_start and a write request in the same cycle; clear wins
    wait_idle();
    @(negedge clock);
    clr_start = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_adr   = 3'd2;
    req_wdata = 8'd9;
    #1;
    check("clr_prio_ready", 32'(req_ready), 32'd0);
    @(posedge clock);
    #1 clr_start = 1'b0;
    clear_seq();
    #1;
    check("req_ready_after_clr", 32'(req_ready), 32'd1);
    @(posedge clock);
    model[2] = 8'd9;
    #1 req_valid = 1'b0;
    @(negedge clock);
    check("late_wr_we",  32'(ram_write_signal), 32'd1);
    check("late_wr_adr", 32'(ram_adr),          32'd2);
    check("late_wr_din", 32'(ram_data_in),      32'd9);
    do_read(3'd2);

    // 6: reset aborts a clear partway through
    send(1'b1, 3'd5, 8'haa, w);
    wait_idle();
    @(negedge clock);
    clr_start = 1'b1;
    @(posedge clock);
    #1 clr_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("abort_clr_adr", 32'(ram_adr),          32'(i));
      check("abort_clr_we",  32'(ram_write_signal), 32'd1);
    end
    reset = 1'b0;
    @(negedge clock);
    check("abort_we",   32'(ram_write_signal), 32'd0);
    check("abort_done", 32'(clr_done),         32'd0);
    check("abort_busy", 32'(busy),             32'd0);
    @(negedge clock);
    check("abort_done2", 32'(clr_done), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = DW'(CV);
    @(negedge clock);
    check("abort_done3", 32'(clr_done), 32'd0);
    do_read(3'd5);
    do_read(3'd3);

    repeat (4) @(negedge clock);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
